game_flow_controller: RTL
=========================

# game_flow_controller

Top-level game sequencer on the VGA clock domain. It decides which screen drawer (title, level, win, game over) feeds the renderer and holds the level drawer in reset outside active play. It also enforces a minimum display time on end screens and keeps the win tally and the optional lives count that appear on the board LEDs.

## Interface
- `HOLD_FRAMES`, 120: frames an end screen must show before a jump press is accepted.
- `RESPAWN_FRAMES`, 60: frames spent in RESPAWN before play resumes (`LIVES_EN` only).
- `START_LIVES`, 3: lives loaded at game start, range 1..3 (`LIVES_EN` only).
- `vga_clock` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `jump_button` in 1: conditioned button, active-high level.
- `frame_tick` in 1: one-cycle pulse per frame at start of vertical blank.
- `play_win` in 1: level drawer `win` flag (level).
- `play_lose` in 1: level drawer `lose` flag (level).
- `screen_sel` out 2: 0 = title, 1 = level, 2 = win, 3 = game over. Top-level mux select for background and sprite coordinates.
- `play_reset` out 1: reset to the level drawer.
- `lives` out 2: remaining lives.
- `wins` out 4: games won since reset, saturating.
- `leds` out 10: [3:0] state one-hot (TITLE, PLAY, WIN, LOSE), [7:4] `wins`, [9:8] `lives`.

## Operation
- States: TITLE, PLAY, WIN, LOSE, plus RESPAWN when `LIVES_EN` is defined.
- Jump edge: `jump_q` is `jump_button` registered. `jump_rise = jump_button & ~jump_q`.
- Hold counter:
  - Width `$clog2(max(HOLD_FRAMES,RESPAWN_FRAMES)+1)`.
  - Cleared on every state change.
  - Increments on `frame_tick`, saturating.
  - `hold_done` means count ≥ the current state's limit.
- Transitions:
  - TITLE → PLAY on `jump_rise`. Reload `lives` from `START_LIVES`.
  - PLAY, armed: `play_lose` → LOSE (or RESPAWN, see Configuration). Otherwise `play_win` → WIN and `wins` increments, saturating at 15. Lose wins a simultaneous win/lose.
  - WIN or LOSE → TITLE on `jump_rise & hold_done`. A press before `hold_done` is discarded, not queued.
  - RESPAWN → PLAY on `hold_done`, with no button needed.
- Arming: `play_win` and `play_lose` are ignored on the first cycle in PLAY, while the drawer's flags clear out of reset.
- Output decode:
  - `screen_sel`: TITLE = 0, PLAY = 1, RESPAWN = 1, WIN = 2, LOSE = 3.
  - `play_reset` = 1 in every state except PLAY.
- Reset values:
  - State TITLE, counter 0, `wins` 0.
  - `lives` = `START_LIVES` (0 without `LIVES_EN`).
  - `jump_q` = 1, so a button held through reset never starts a game.
  - `screen_sel` = 0, `play_reset` = 1, `leds` = 10'b?? per the field map, i.e. `lives`, 0000, 0001.
- Reset mid-game: immediate return to all reset values on the next edge, whatever the state.

## Timing
- All outputs are registered. A transition triggered at edge N shows on `screen_sel`, `play_reset` and `leds` after edge N.
- Jump latency: press level at edge N-1 → `jump_rise` at edge N → state change visible after edge N.
- `hold_done` in WIN/LOSE is reached on the `HOLD_FRAMES`-th `frame_tick` after entry. A tick in the entry cycle is not counted.
- `play_reset` deasserts in the same cycle `screen_sel` becomes 1 from TITLE. The level drawer sees exactly one reset-free cycle before arming.

## Configuration
- `GAME_FLOW_LIVES_EN` defined:
  - In PLAY, `play_lose` with `lives > 1` → RESPAWN and `lives` decrements.
  - With `lives == 1` → LOSE and `lives` becomes 0.
- Undefined:
  - `lives` is tied to 0, RESPAWN is not generated, and any lose → LOSE.
  - `RESPAWN_FRAMES` and `START_LIVES` are unused.

## Structure
- Shared package `game_pkg`:
  - State enum `game_state_t`.
  - Screen select constants `SCR_TITLE`, `SCR_LEVEL`, `SCR_WIN`, `SCR_OVER`.
  - LED field offsets.
- Sub-module `frame_hold_timer`: clear, tick, limit inputs; `done` output. Saturating frame counter, reusable by other drawers.
- The FSM, edge detect, tallies and output decode stay in `game_flow_controller`.

## Test plan
- Reset with `jump_button` held at 1, release, then press: no leave from TITLE until the press. `screen_sel` 0→1 one cycle after the rise, `play_reset` 1→0.
- In PLAY, pulse `play_win` and `play_lose` in the same cycle: enters LOSE, `screen_sel`=3, `wins` unchanged.
- WIN with `HOLD_FRAMES`=4: press after 2 ticks is ignored. Press after the 4th tick → TITLE, `wins`=1, `leds[7:4]`=0001.
- 16 consecutive wins: `wins` saturates at 15 and never wraps to 0.
- `LIVES_EN`, `START_LIVES`=3, `RESPAWN_FRAMES`=2: lose → RESPAWN with `lives`=2. Back to PLAY after 2 ticks, no button. Third lose → LOSE with `lives`=0.
- Assert `reset` mid-RESPAWN: next cycle shows TITLE, `lives`=3, counter 0, `play_reset`=1.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared types and constants for the game sequencer and screen drawers.
//   game_state_t   - sequencer state enum
//   SCR_*          - screen_sel encodings for the top-level background/sprite mux
//   LED_*_LSB      - field offsets inside the 10-bit board LED word
//   screen_of()    - state to screen_sel decode
//   state_onehot() - state to LED one-hot field decode
package game_pkg;

   localparam int unsigned SCR_W   = 2;
   localparam int unsigned LIVES_W = 2;
   localparam int unsigned WINS_W  = 4;
   localparam int unsigned LEDS_W  = 10;

   localparam int unsigned LED_STATE_LSB = 0;
   localparam int unsigned LED_WINS_LSB  = 4;
   localparam int unsigned LED_LIVES_LSB = 8;

   localparam logic [SCR_W-1:0] SCR_TITLE = 2'd0;
   localparam logic [SCR_W-1:0] SCR_LEVEL = 2'd1;
   localparam logic [SCR_W-1:0] SCR_WIN   = 2'd2;
   localparam logic [SCR_W-1:0] SCR_OVER  = 2'd3;

   typedef enum logic [2:0] {
      ST_TITLE   = 3'd0,
      ST_PLAY    = 3'd1,
      ST_WIN     = 3'd2,
      ST_LOSE    = 3'd3,
      ST_RESPAWN = 3'd4
   } game_state_t;

   // RESPAWN keeps the level on screen between lives
   function automatic logic [SCR_W-1:0] screen_of(input game_state_t s);
      case (s)
         ST_TITLE:   return SCR_TITLE;
         ST_PLAY:    return SCR_LEVEL;
         ST_RESPAWN: return SCR_LEVEL;
         ST_WIN:     return SCR_WIN;
         ST_LOSE:    return SCR_OVER;
         default:    return SCR_TITLE;
      endcase
   endfunction

   // RESPAWN shows as PLAY on the LEDs
   function automatic logic [3:0] state_onehot(input game_state_t s);
      case (s)
         ST_TITLE:   return 4'b0001;
         ST_PLAY:    return 4'b0010;
         ST_RESPAWN: return 4'b0010;
         ST_WIN:     return 4'b0100;
         ST_LOSE:    return 4'b1000;
         default:    return 4'b0001;
      endcase
   endfunction

endpackage

// File: rtl/frame_hold_timer.sv
// frame_hold_timer: saturating frame counter with a threshold compare.
//   clk, reset : clock, synchronous active-high reset
//   clear      : zero the count (wins over tick)
//   tick       : one-cycle frame pulse, counted when not clearing
//   limit      : threshold for done
//   done       : count >= limit (decoded from the count register)
module frame_hold_timer #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             tick,
   input  logic [CNT_W-1:0] limit,
   output logic             done
);

   logic [CNT_W-1:0] count;

   // count frames, sticking at all-ones
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (tick && (count != '1)) begin
         count <= count + CNT_W'(1);
      end
   end

   assign done = (count >= limit);

endmodule

// File: rtl/game_flow_controller.sv
// game_flow_controller: top-level game sequencer on the VGA clock domain.
//   vga_clock, reset : sole clock, synchronous active-high reset
//   jump_button      : conditioned button level; rising edge starts/leaves screens
//   frame_tick       : one pulse per frame at start of vertical blank
//   play_win/lose    : level drawer result flags
//   screen_sel       : 0 title, 1 level, 2 win, 3 game over (registered)
//   play_reset       : level drawer reset, high outside PLAY (registered)
//   lives, wins      : remaining lives, saturating win tally (registered)
//   leds             : {lives, wins, state one-hot TITLE/PLAY/WIN/LOSE} (registered)
// Optional feature macro: GAME_FLOW_LIVES_EN adds lives and the RESPAWN state.
module game_flow_controller
   import game_pkg::*;
#(
   parameter int unsigned HOLD_FRAMES    = 120,
   parameter int unsigned RESPAWN_FRAMES = 60,
   parameter int unsigned START_LIVES    = 3
) (
   input  logic               vga_clock,
   input  logic               reset,
   input  logic               jump_button,
   input  logic               frame_tick,
   input  logic               play_win,
   input  logic               play_lose,
   output logic [SCR_W-1:0]   screen_sel,
   output logic               play_reset,
   output logic [LIVES_W-1:0] lives,
   output logic [WINS_W-1:0]  wins,
   output logic [LEDS_W-1:0]  leds
);

   localparam int unsigned MAX_FRAMES = (HOLD_FRAMES > RESPAWN_FRAMES) ? HOLD_FRAMES : RESPAWN_FRAMES;
   localparam int unsigned CNT_W      = $clog2(MAX_FRAMES + 1);

`ifdef GAME_FLOW_LIVES_EN
   localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(START_LIVES);
`else
   localparam logic [LIVES_W-1:0] LIVES_INIT = '0;
`endif

   // empty marker block: only elaborates for an unsupported START_LIVES
   if ((START_LIVES < 1) || (START_LIVES > 3)) begin : g_start_lives_out_of_range
   end

   game_state_t        state, state_next;
   logic               jump_q;
   logic               jump_rise;
   logic               armed;
   logic               hold_done;
   logic [CNT_W-1:0]   hold_limit;
   logic [LIVES_W-1:0] lives_next;
   logic [WINS_W-1:0]  wins_next;

   assign jump_rise  = jump_button & ~jump_q;
   assign hold_limit = (state == ST_RESPAWN) ? CNT_W'(RESPAWN_FRAMES) : CNT_W'(HOLD_FRAMES);

   // end-screen / respawn timer, restarted on every state change
   frame_hold_timer #(
      .CNT_W (CNT_W)
   ) u_hold (
      .clk   (vga_clock),
      .reset (reset),
      .clear (state_next != state),
      .tick  (frame_tick),
      .limit (hold_limit),
      .done  (hold_done)
   );

   // next state and tallies
   always_comb begin
      state_next = state;
      lives_next = lives;
      wins_next  = wins;
      case (state)
         ST_TITLE: begin
            if (jump_rise) begin
               state_next = ST_PLAY;
               lives_next = LIVES_INIT;
            end
         end
         ST_PLAY: begin
            // flags are ignored on the first PLAY cycle while the drawer leaves reset
            if (armed) begin
               if (play_lose) begin
`ifdef GAME_FLOW_LIVES_EN
                  if (lives > LIVES_W'(1)) begin
                     state_next = ST_RESPAWN;
                     lives_next = lives - LIVES_W'(1);
                  end else begin
                     state_next = ST_LOSE;
                     lives_next = '0;
                  end
`else
                  state_next = ST_LOSE;
`endif
               end else if (play_win) begin
                  state_next = ST_WIN;
                  if (wins != '1) begin
                     wins_next = wins + WINS_W'(1);
                  end
               end
            end
         end
         ST_WIN, ST_LOSE: begin
            if (jump_rise && hold_done) begin
               state_next = ST_TITLE;
            end
         end
         ST_RESPAWN: begin
            if (hold_done) begin
               state_next = ST_PLAY;
            end
         end
         default: state_next = ST_TITLE;
      endcase
`ifndef GAME_FLOW_LIVES_EN
      lives_next = '0;
`endif
   end

   // state register and outputs decoded from the next state so they align with it
   always_ff @(posedge vga_clock) begin
      if (reset) begin
         state      <= ST_TITLE;
         jump_q     <= 1'b1;
         armed      <= 1'b0;
         lives      <= LIVES_INIT;
         wins       <= '0;
         screen_sel <= SCR_TITLE;
         play_reset <= 1'b1;
         leds       <= {LIVES_INIT, WINS_W'(0), state_onehot(ST_TITLE)};
      end else begin
         state      <= state_next;
         jump_q     <= jump_button;
         armed      <= (state == ST_PLAY) && (state_next == ST_PLAY);
         lives      <= lives_next;
         wins       <= wins_next;
         screen_sel <= screen_of(state_next);
         play_reset <= (state_next != ST_PLAY);
         leds[LED_STATE_LSB +: 4]       <= state_onehot(state_next);
         leds[LED_WINS_LSB  +: WINS_W]  <= wins_next;
         leds[LED_LIVES_LSB +: LIVES_W] <= lives_next;
      end
   end

endmodule
